sdram_port_arbiter: RTL

- Two-master, one-slave arbiter that shares the single SDRAM controller port between two Avalon-MM requesters, for example the CPU data master and a DMA/video reader.
- Sits between the requesters and the SDRAM controller slave, inside the same clock domain as the controller.
- Provides round-robin grant with bounded hold, and pipelined-read support with variable latency.
- Routes each read response back to the master that issued the read, using an in-order owner FIFO.

---
 rtl/sdram_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of one SDRAM controller port.
// Read responses are routed back in order through a 1-bit owner FIFO.
module sdram_port_arbiter #(
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 16,
   parameter int BE_W        = DATA_W / 8,
   parameter int MAX_PENDING = 4,
   parameter int MAX_HOLD    = 8
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic [ADDR_W-1:0]             m0_address,
   input  logic                          m0_read,
   input  logic                          m0_write,
   input  logic [DATA_W-1:0]             m0_writedata,
   input  logic [BE_W-1:0]               m0_byteenable,
   output logic                          m0_waitrequest,
   output logic [DATA_W-1:0]             m0_readdata,
   output logic                          m0_readdatavalid,
   input  logic [ADDR_W-1:0]             m1_address,
   input  logic                          m1_read,
   input  logic                          m1_write,
   input  logic [DATA_W-1:0]             m1_writedata,
   input  logic [BE_W-1:0]               m1_byteenable,
   output logic                          m1_waitrequest,
   output logic [DATA_W-1:0]             m1_readdata,
   output logic                          m1_readdatavalid,
   output logic [ADDR_W-1:0]             s_address,
   output logic                          s_read,
   output logic                          s_write,
   output logic [DATA_W-1:0]             s_writedata,
   output logic [BE_W-1:0]               s_byteenable,
   input  logic                          s_waitrequest,
   input  logic [DATA_W-1:0]             s_readdata,
   input  logic                          s_readdatavalid,
   output logic [$clog2(MAX_PENDING):0]  pending_cnt,
   output logic                          err_unexpected_rdv
);

   localparam int PTR_W  = $clog2(MAX_PENDING);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(MAX_PENDING);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t              state_q, state_d;
   logic                last_gnt_q, last_gnt_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [MAX_PENDING-1:0] fifo_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]      cnt_q;
   logic                err_q;

   logic req0, req1, sel1, granted;
   logic own_req, oth_req;
   logic mx_read, mx_write, rd_eff;
   logic fifo_full, fifo_empty, head;
   logic stall, accept, push, pop;

   assign req0    = m0_read | m0_write;
   assign req1    = m1_read | m1_write;
   assign sel1    = (state_q == GNT1);
   assign granted = (state_q != IDLE) & ~reset_reset;
   assign own_req = sel1 ? req1 : req0;
   assign oth_req = sel1 ? req0 : req1;

   assign mx_read  = sel1 ? m1_read  : m0_read;
   assign mx_write = sel1 ? m1_write : m0_write;
   // write wins if a master illegally asserts both
   assign rd_eff   = mx_read & ~mx_write;

   assign fifo_full  = (cnt_q == FULL_CNT);
   assign fifo_empty = (cnt_q == '0);
   assign head       = fifo_q[rd_ptr_q];

   assign s_address    = sel1 ? m1_address    : m0_address;
   assign s_writedata  = sel1 ? m1_writedata  : m0_writedata;
   assign s_byteenable = sel1 ? m1_byteenable : m0_byteenable;
   assign s_read       = granted & rd_eff & ~fifo_full;
   assign s_write      = granted & mx_write;

   assign stall          = s_waitrequest | (rd_eff & fifo_full);
   assign m0_waitrequest = ~(granted & ~sel1) | stall;
   assign m1_waitrequest = ~(granted & sel1) | stall;

   assign accept = (s_read | s_write) & ~s_waitrequest;
   assign push   = s_read & ~s_waitrequest;
   assign pop    = s_readdatavalid & ~fifo_empty;

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = pop & ~head;
   assign m1_readdatavalid = pop & head;

   assign pending_cnt        = cnt_q;
   assign err_unexpected_rdv = err_q;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      last_gnt_d = last_gnt_q;
      case (state_q)
         IDLE: begin
            if (req0 && (!req1 || last_gnt_q)) state_d = GNT0;
            else if (req1)                     state_d = GNT1;
         end
         GNT0, GNT1: begin
            if (!own_req) begin
               hold_d  = '0;
               state_d = oth_req ? (sel1 ? GNT0 : GNT1) : IDLE;
            end else if (accept) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = '0;
                  if (oth_req) state_d = sel1 ? GNT0 : GNT1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == GNT0)      last_gnt_d = 1'b0;
      else if (state_d == GNT1) last_gnt_d = 1'b1;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         hold_q     <= '0;
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         hold_q     <= hold_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= sel1;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (s_readdatavalid && fifo_empty) err_q <= 1'b1;
      end
   end

endmodule
